// File: rtl/code_lock_checker.sv
// Parametrised combination-lock checker: compares a digit stream (MS digit first) against CODE.
// Optional timed lockout after MAX_TRIES consecutive failures is built when LOCKOUT_EN is defined.
module code_lock_checker #(
    parameter int unsigned                       DIGIT_W     = 4,
    parameter int unsigned                       CODE_LEN    = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]       CODE        = 16'h1234,
    parameter int unsigned                       MAX_TRIES   = 3,
    parameter int unsigned                       LOCK_CYCLES = 16
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 INIT,
    input  logic [DIGIT_W-1:0]                   digit,
    input  logic                                 digit_vld,
    output logic                                 check,
    output logic                                 fail,
    output logic                                 busy,
    output logic                                 locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]       fail_cnt
);

    localparam int unsigned IDX_W = $clog2(CODE_LEN + 1);
    localparam int unsigned CNT_W = $clog2(MAX_TRIES + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ENTER  = 3'd1;
    localparam logic [2:0] S_UNLOCK = 3'd2;
    localparam logic [2:0] S_FAIL   = 3'd3;
`ifdef LOCKOUT_EN
    localparam logic [2:0] S_LOCKOUT = 3'd4;
    localparam int unsigned TMR_W    = $clog2(LOCK_CYCLES + 1);
`endif

    if (DIGIT_W < 1 || CODE_LEN < 1 || MAX_TRIES < 1 || LOCK_CYCLES < 1) begin : g_bad_params
        $error("code_lock_checker: DIGIT_W, CODE_LEN, MAX_TRIES and LOCK_CYCLES must all be >= 1");
    end

    logic [2:0]         state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic               mism, mism_nxt;
    logic [CNT_W-1:0]   cnt_nxt, cnt_inc;
    logic [DIGIT_W-1:0] code_digit;
    logic               digit_bad;
    logic               last_digit;
    logic               cnt_at_max;
`ifdef LOCKOUT_EN
    logic [TMR_W-1:0]   tmr, tmr_nxt;
`endif

    always_comb begin
        code_digit = '0;
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (32'(idx) == i) begin
                code_digit = CODE[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign digit_bad  = (digit != code_digit);
    assign last_digit = (idx == IDX_W'(CODE_LEN - 1));
    assign cnt_at_max = (fail_cnt == CNT_W'(MAX_TRIES));
    assign cnt_inc    = cnt_at_max ? fail_cnt : fail_cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        mism_nxt  = mism;
        cnt_nxt   = fail_cnt;
`ifdef LOCKOUT_EN
        tmr_nxt   = tmr;
`endif
        case (state)
            S_IDLE, S_UNLOCK: begin
                if (INIT) begin
                    state_nxt = S_ENTER;
                    idx_nxt   = '0;
                    mism_nxt  = 1'b0;
                end
            end
            S_ENTER: begin
                // INIT wins over a same-cycle digit, which is dropped
                if (INIT) begin
                    idx_nxt  = '0;
                    mism_nxt = 1'b0;
                end else if (digit_vld) begin
                    if (last_digit) begin
                        idx_nxt  = '0;
                        mism_nxt = 1'b0;
                        if (mism || digit_bad) begin
                            state_nxt = S_FAIL;
                            cnt_nxt   = cnt_inc;
                        end else begin
                            state_nxt = S_UNLOCK;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        idx_nxt  = idx + IDX_W'(1);
                        mism_nxt = mism | digit_bad;
                    end
                end
            end
            S_FAIL: begin
`ifdef LOCKOUT_EN
                if (cnt_at_max) begin
                    state_nxt = S_LOCKOUT;
                    tmr_nxt   = TMR_W'(LOCK_CYCLES - 1);
                end else begin
                    state_nxt = S_IDLE;
                end
`else
                state_nxt = S_IDLE;
`endif
            end
`ifdef LOCKOUT_EN
            S_LOCKOUT: begin
                if (tmr == '0) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
                mism_nxt  = 1'b0;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with the state they describe
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            idx      <= '0;
            mism     <= 1'b0;
            fail_cnt <= '0;
            check    <= 1'b0;
            fail     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            mism     <= mism_nxt;
            fail_cnt <= cnt_nxt;
            check    <= (state_nxt == S_UNLOCK);
            fail     <= (state_nxt == S_FAIL);
            busy     <= (state_nxt == S_ENTER);
        end
    end

`ifdef LOCKOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            tmr    <= '0;
            locked <= 1'b0;
        end else begin
            tmr    <= tmr_nxt;
            locked <= (state_nxt == S_LOCKOUT);
        end
    end
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_code_lock_checker.sv
// Bench for code_lock_checker: directed entries, per-cycle model comparison, literal spot checks.
// Honours LOCKOUT_EN the same way as the design.
module tb_code_lock_checker;

    localparam int unsigned DW = 4;
    localparam int unsigned CL = 4;
    localparam int unsigned MT = 3;
    localparam int unsigned LC = 16;
    localparam logic [15:0] CODE_V = 16'h1234;
`ifdef LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          INIT = 1'b0;
    logic [DW-1:0] digit = '0;
    logic          digit_vld = 1'b0;
    logic          check, fail, busy, locked;
    logic [1:0]    fail_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    code_lock_checker #(
        .DIGIT_W    (DW),
        .CODE_LEN   (CL),
        .CODE       (CODE_V),
        .MAX_TRIES  (MT),
        .LOCK_CYCLES(LC)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .INIT     (INIT),
        .digit    (digit),
        .digit_vld(digit_vld),
        .check    (check),
        .fail     (fail),
        .busy     (busy),
        .locked   (locked),
        .fail_cnt (fail_cnt)
    );

    // Behavioural model: remembers the digits typed and judges the whole entry at the end
    typedef struct {
        bit entering;
        bit unlocked;
        bit failp;
        int tries;
        int lock_left;
        int n;
        int got[CL];
    } mdl_t;

    mdl_t m;
    bit   live = 1'b0;

    function automatic int code_digit(input int k);
        return int'((CODE_V >> ((CL - 1 - k) * DW)) & 16'h000F);
    endfunction

    function automatic mdl_t step(input mdl_t s, input logic r, input logic i,
                                  input logic v, input logic [DW-1:0] d);
        mdl_t t;
        bit   ok;
        t = s;
        if (r) begin
            t.entering = 0; t.unlocked = 0; t.failp = 0;
            t.tries = 0; t.lock_left = 0; t.n = 0;
            return t;
        end
        if (t.lock_left > 0) begin
            t.lock_left = t.lock_left - 1;
            if (t.lock_left == 0) t.tries = 0;
            return t;
        end
        if (t.failp) begin
            t.failp = 0;
            if (LOCKOUT && t.tries == MT) t.lock_left = LC;
            return t;
        end
        if (i) begin
            t.entering = 1; t.unlocked = 0; t.n = 0;
            return t;
        end
        if (t.entering && v) begin
            t.got[t.n] = int'(d);
            t.n = t.n + 1;
            if (t.n == CL) begin
                t.entering = 0;
                ok = 1;
                for (int k = 0; k < CL; k++)
                    if (t.got[k] != code_digit(k)) ok = 0;
                if (ok) begin
                    t.unlocked = 1;
                    t.tries = 0;
                end else begin
                    t.failp = 1;
                    if (t.tries < MT) t.tries = t.tries + 1;
                end
            end
        end
        return t;
    endfunction

    always @(posedge CLK) begin
        m <= step(m, RST, INIT, digit_vld, digit);
        if (RST) live <= 1'b1;
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (live) begin
            cmp("model.check",    32'(check),    32'(m.unlocked));
            cmp("model.fail",     32'(fail),     32'(m.failp));
            cmp("model.busy",     32'(busy),     32'(m.entering));
            cmp("model.locked",   32'(locked),   32'(m.lock_left > 0));
            cmp("model.fail_cnt", 32'(fail_cnt), 32'(m.tries));
        end
    end

    task automatic cyc(input logic i, input logic v, input logic [DW-1:0] d, input logic r);
        RST = r; INIT = i; digit_vld = v; digit = d;
        @(posedge CLK);
        #1;
        RST = 1'b0; INIT = 1'b0; digit_vld = 1'b0; digit = '0;
    endtask

    task automatic entry(input int a, input int b, input int c, input int e, input int gap);
        int ds[4];
        ds = '{a, b, c, e};
        cyc(1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, DW'(ds[k]), 1'b0);
            if (k < 3) repeat (gap) cyc(1'b0, 1'b0, '0, 1'b0);
        end
    endtask

    initial begin
        // 1. reset
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cmp("rst.check", 32'(check), 0);
        cmp("rst.fail", 32'(fail), 0);
        cmp("rst.busy", 32'(busy), 0);
        cmp("rst.locked", 32'(locked), 0);
        cmp("rst.fail_cnt", 32'(fail_cnt), 0);

        // 2. correct code, hold, re-INIT
        cyc(1'b1, 1'b0, '0, 1'b0);
        cmp("init.busy", 32'(busy), 1);
        entry(1, 2, 3, 4, 0);
        cmp("ok.check", 32'(check), 1);
        cmp("ok.busy", 32'(busy), 0);
        repeat (10) cyc(1'b0, 1'b0, '0, 1'b0);
        cmp("hold.check", 32'(check), 1);
        cyc(1'b1, 1'b0, '0, 1'b0);
        cmp("reinit.check", 32'(check), 0);
        cmp("reinit.busy", 32'(busy), 1);

        // 3. wrong code, then correct
        entry(1, 2, 3, 5, 0);
        cmp("bad.fail", 32'(fail), 1);
        cmp("bad.fail_cnt", 32'(fail_cnt), 1);
        cmp("bad.check", 32'(check), 0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        cmp("bad.fail_pulse", 32'(fail), 0);
        entry(1, 2, 3, 4, 0);
        cmp("retry.check", 32'(check), 1);
        cmp("retry.fail_cnt", 32'(fail_cnt), 0);

        // 4. INIT with a same-cycle digit mid-entry, then gapped digits
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 4'd1, 1'b0);
        cyc(1'b0, 1'b1, 4'd2, 1'b0);
        cyc(1'b1, 1'b1, 4'd9, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, 1'b1, DW'(k), 1'b0);
            if (k < 4) repeat (3) cyc(1'b0, 1'b0, '0, 1'b0);
        end
        cmp("restart.check", 32'(check), 1);

        // 5. reset mid-entry; stray digit afterwards
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 4'd1, 1'b0);
        cyc(1'b0, 1'b1, 4'd2, 1'b0);
        cyc(1'b0, 1'b1, 4'd3, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b1, 4'd4, 1'b0);
        cmp("midrst.check", 32'(check), 0);
        cmp("midrst.busy", 32'(busy), 0);

        // 6. three consecutive failures; INIT during the fail pulse is ignored
        entry(1, 2, 3, 5, 0);
        cyc(1'b1, 1'b0, '0, 1'b0);
        cmp("failinit.busy", 32'(busy), 0);
        cmp("failinit.fail_cnt", 32'(fail_cnt), 1);
        entry(5, 2, 3, 4, 1);
        cyc(1'b0, 1'b0, '0, 1'b0);
        entry(1, 2, 4, 4, 0);
        cmp("third.fail", 32'(fail), 1);
        cmp("third.fail_cnt", 32'(fail_cnt), 3);
        cyc(1'b0, 1'b0, '0, 1'b0);
        if (LOCKOUT) begin
            cmp("lock.locked", 32'(locked), 1);
            cyc(1'b1, 1'b0, '0, 1'b0);
            cmp("lock.init_ignored", 32'(busy), 0);
            repeat (14) cyc(1'b0, 1'b0, '0, 1'b0);
            cmp("lock.last", 32'(locked), 1);
            cyc(1'b0, 1'b0, '0, 1'b0);
            cmp("lock.released", 32'(locked), 0);
            cmp("lock.fail_cnt", 32'(fail_cnt), 0);
        end else begin
            cmp("nolock.locked", 32'(locked), 0);
            cyc(1'b0, 1'b0, '0, 1'b0);
            cmp("nolock.fail_cnt", 32'(fail_cnt), 3);
        end
        entry(1, 2, 3, 4, 0);
        cmp("final.check", 32'(check), 1);
        cmp("final.fail_cnt", 32'(fail_cnt), 0);

        repeat (3) cyc(1'b0, 1'b0, '0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
